// File: rtl/ascon_pkg.sv
// Shared constants and encodings for the Ascon pin-side loader.
// Select codes, default widths, block type and buffer state types.
package ascon_pkg;

  localparam logic [1:0] SEL_KEY   = 2'd0;
  localparam logic [1:0] SEL_NONCE = 2'd1;
  localparam logic [1:0] SEL_AD    = 2'd2;
  localparam logic [1:0] SEL_PT    = 2'd3;

  localparam int KEY_W_DEF   = 128;
  localparam int NONCE_W_DEF = 128;
  localparam int BLK_W_DEF   = 64;

  typedef enum logic {
    BLK_AD = 1'b0,
    BLK_PT = 1'b1
  } blk_type_e;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // A block select has bit 1 set; bit 0 then gives the block type.
  function automatic logic is_blk(input logic [1:0] s);
    return s[1];
  endfunction

endpackage

// File: rtl/ascon_io_loader_if.sv
// Block handoff from the serial loader to the Ascon core.
// Valid/ready handshake carrying one rate-sized data block.
interface ascon_io_loader_if
  import ascon_pkg::*;
#(
  parameter int BLK_W = BLK_W_DEF
);

  logic [BLK_W-1:0] blk_o;
  logic             blk_type_o;
  logic             blk_last_o;
  logic             blk_valid_o;
  logic             blk_ready_i;

  modport master (
    output blk_o,
    output blk_type_o,
    output blk_last_o,
    output blk_valid_o,
    input  blk_ready_i
  );

  modport slave (
    input  blk_o,
    input  blk_type_o,
    input  blk_last_o,
    input  blk_valid_o,
    output blk_ready_i
  );

endinterface

// File: rtl/ascon_shift_in.sv
// Serial deserializer: shift register, bit counter and select tracking.
// Flags the cycle whose bit completes a word and exposes that word.
module ascon_shift_in
  import ascon_pkg::*;
#(
  parameter int KEY_W   = KEY_W_DEF,
  parameter int NONCE_W = NONCE_W_DEF,
  parameter int BLK_W   = BLK_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sdi_i,
  input  logic             sen_i,
  input  logic [1:0]       sel_i,
  input  logic             last_i,
  output logic             commit_o,
  output logic [1:0]       csel_o,
  output logic             clast_o,
  output logic [KEY_W-1:0] word_o
);

  localparam logic [7:0] KEY_LEN   = 8'(KEY_W);
  localparam logic [7:0] NONCE_LEN = 8'(NONCE_W);
  localparam logic [7:0] BLK_LEN   = 8'(BLK_W);

  logic [KEY_W-1:0] sr_q, sr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;

  logic       restart;
  logic       first;
  logic [1:0] cur_sel;
  logic [7:0] base;
  logic [7:0] wlen;
  logic       commit;

  // Next-state for shifting, counting and word completion.
  always_comb begin
    restart = (cnt_q != 8'd0) && (sel_i != sel_q);
    first   = (cnt_q == 8'd0) || restart;
    cur_sel = first ? sel_i : sel_q;
    base    = first ? 8'd0 : cnt_q;
    unique case (1'b1)
      is_blk(cur_sel):        wlen = BLK_LEN;
      (cur_sel == SEL_NONCE): wlen = NONCE_LEN;
      default:                wlen = KEY_LEN;
    endcase
    sr_d   = sr_q;
    cnt_d  = restart ? 8'd0 : cnt_q;
    sel_d  = sel_q;
    commit = 1'b0;
    if (sen_i) begin
      sr_d  = {sr_q[KEY_W-2:0], sdi_i};
      sel_d = cur_sel;
      if (base == wlen - 8'd1) begin
        commit = 1'b1;
        cnt_d  = 8'd0;
      end else begin
        cnt_d = base + 8'd1;
      end
    end
  end

  // Shift state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  assign commit_o = commit;
  assign csel_o   = cur_sel;
  assign clast_o  = last_i;
  assign word_o   = sr_d;

endmodule

// File: rtl/ascon_io_loader.sv
// Pin-side serial loader feeding the Ascon core.
// Routes committed words, holds one block and issues the init strobe.
module ascon_io_loader
  import ascon_pkg::*;
#(
  parameter int KEY_W   = KEY_W_DEF,
  parameter int NONCE_W = NONCE_W_DEF,
  parameter int BLK_W   = BLK_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sdi,
  input  logic               sen,
  input  logic [1:0]         sel,
  input  logic               go,
  input  logic               last,
  output logic [KEY_W-1:0]   key_o,
  output logic [NONCE_W-1:0] nonce_o,
  output logic               init_o,
  output logic               kn_ok_o,
  output logic               err_o,
  ascon_io_loader_if.master  bus
);

  logic             commit;
  logic [1:0]       csel;
  logic             clast;
  logic [KEY_W-1:0] word;

  ascon_shift_in #(
    .KEY_W   (KEY_W),
    .NONCE_W (NONCE_W),
    .BLK_W   (BLK_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .sdi_i    (sdi),
    .sen_i    (sen),
    .sel_i    (sel),
    .last_i   (last),
    .commit_o (commit),
    .csel_o   (csel),
    .clast_o  (clast),
    .word_o   (word)
  );

  logic [KEY_W-1:0]   key_q;
  logic [NONCE_W-1:0] nonce_q;
  logic               key_v_q;
  logic               nonce_v_q;
  logic               kn_ok_q;

  logic key_cm;
  logic nonce_cm;
  logic blk_cm;

  assign key_cm   = commit && (csel == SEL_KEY);
  assign nonce_cm = commit && (csel == SEL_NONCE);
  assign blk_cm   = commit && is_blk(csel);

  // Key/nonce capture; a recommit simply overwrites.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q     <= '0;
      nonce_q   <= '0;
      key_v_q   <= 1'b0;
      nonce_v_q <= 1'b0;
      kn_ok_q   <= 1'b0;
    end else begin
      if (key_cm) begin
        key_q   <= word;
        key_v_q <= 1'b1;
      end
      if (nonce_cm) begin
        nonce_q   <= word[NONCE_W-1:0];
        nonce_v_q <= 1'b1;
      end
      kn_ok_q <= key_v_q && nonce_v_q;
    end
  end

  buf_state_e       st_q;
  logic [BLK_W-1:0] blk_q;
  logic             type_q;
  logic             blast_q;
  logic             bvalid_q;
  logic             go_q;
  logic             init_q;
  logic             err_q;

  logic drain;
  logic go_edge;

  assign drain   = (st_q == BUF_FULL) && bus.blk_ready_i;
  assign go_edge = go && !go_q;

  // Holding buffer FSM with go handling and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= BUF_EMPTY;
      blk_q    <= '0;
      type_q   <= 1'b0;
      blast_q  <= 1'b0;
      bvalid_q <= 1'b0;
      go_q     <= 1'b0;
      init_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      go_q   <= go;
      init_q <= 1'b0;
      unique case (st_q)
        BUF_EMPTY: begin
          if (blk_cm) begin
            blk_q    <= word[BLK_W-1:0];
            type_q   <= csel[0];
            blast_q  <= clast;
            bvalid_q <= 1'b1;
            st_q     <= BUF_FULL;
          end
        end
        BUF_FULL: begin
          if (blk_cm && drain) begin
            blk_q   <= word[BLK_W-1:0];
            type_q  <= csel[0];
            blast_q <= clast;
          end else if (blk_cm) begin
            err_q <= 1'b1;
          end else if (drain) begin
            bvalid_q <= 1'b0;
            st_q     <= BUF_EMPTY;
          end
        end
        default: st_q <= BUF_EMPTY;
      endcase
      if (go_edge) begin
        if (kn_ok_q && (st_q == BUF_EMPTY)) begin
          init_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign key_o           = key_q;
  assign nonce_o         = nonce_q;
  assign kn_ok_o         = kn_ok_q;
  assign init_o          = init_q;
  assign err_o           = err_q;
  assign bus.blk_o       = blk_q;
  assign bus.blk_type_o  = type_q;
  assign bus.blk_last_o  = blast_q;
  assign bus.blk_valid_o = bvalid_q;

endmodule

// File: tb/tb_ascon_io_loader.sv
// Directed bench for the Ascon serial loader.
// Table of block loads plus hand sequences for multi-cycle cases.
module tb_ascon_io_loader;
  import ascon_pkg::*;

  logic         clk;
  logic         rst;
  logic         sdi;
  logic         sen;
  logic [1:0]   sel;
  logic         go;
  logic         last;
  logic [127:0] key_o;
  logic [127:0] nonce_o;
  logic         init_o;
  logic         kn_ok_o;
  logic         err_o;

  ascon_io_loader_if #(.BLK_W(64)) bif ();

  ascon_io_loader dut (
    .clk     (clk),
    .rst     (rst),
    .sdi     (sdi),
    .sen     (sen),
    .sel     (sel),
    .go      (go),
    .last    (last),
    .key_o   (key_o),
    .nonce_o (nonce_o),
    .init_o  (init_o),
    .kn_ok_o (kn_ok_o),
    .err_o   (err_o),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [1:0]  sel;
    logic [63:0] data;
    logic        last;
    logic        exp_type;
    logic        exp_last;
  } blk_vec_t;

  blk_vec_t vecs [4];

  localparam logic [127:0] KEY   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] NONCE = 128'h101112131415161718191A1B1C1D1E1F;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sen = 1'b0;
    go  = 1'b0;
    bif.blk_ready_i = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic shift_word(input logic [1:0] s, input logic [127:0] d,
                            input int w, input logic l, input logic rdy_last);
    for (int i = w - 1; i >= 0; i--) begin
      sel  = s;
      sdi  = d[i];
      sen  = 1'b1;
      last = l;
      if (i == 0) bif.blk_ready_i = rdy_last;
      tick();
    end
    sen = 1'b0;
    bif.blk_ready_i = 1'b0;
  endtask

  initial begin
    int ninit;
    int first_at;
    n_chk  = 0;
    n_fail = 0;
    sdi    = 1'b0;
    sel    = 2'd0;
    last   = 1'b0;

    vecs[0] = '{SEL_AD, 64'h0123456789ABCDEF, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{SEL_PT, 64'hAAAAAAAAAAAAAAAA, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{SEL_AD, 64'h5555555555555555, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{SEL_PT, 64'hDEADBEEFCAFEF00D, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    sen = 1'b0;
    go  = 1'b0;
    bif.blk_ready_i = 1'b0;
    tick();
    tick();
    chk("rst_key", key_o, 0);
    chk("rst_nonce", nonce_o, 0);
    chk("rst_blk", bif.blk_o, 0);
    chk("rst_valid", bif.blk_valid_o, 0);
    chk("rst_type", bif.blk_type_o, 0);
    chk("rst_last", bif.blk_last_o, 0);
    chk("rst_init", init_o, 0);
    chk("rst_knok", kn_ok_o, 0);
    chk("rst_err", err_o, 0);
    rst = 1'b0;
    tick();

    shift_word(SEL_KEY, KEY, 128, 1'b0, 1'b0);
    chk("key_val", key_o, KEY);
    chk("knok_key_only", kn_ok_o, 0);
    shift_word(SEL_NONCE, NONCE, 128, 1'b0, 1'b0);
    chk("nonce_val", nonce_o, NONCE);
    chk("knok_at_commit", kn_ok_o, 0);
    tick();
    chk("knok_after", kn_ok_o, 1);
    chk("err_kn", err_o, 0);

    go = 1'b1;
    ninit = 0;
    first_at = -1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (init_o) begin
        ninit++;
        if (first_at < 0) first_at = i;
      end
    end
    go = 1'b0;
    chk("init_count", 128'(ninit), 1);
    chk("init_cycle", 128'(first_at), 0);
    chk("err_go", err_o, 0);

    for (int v = 0; v < 4; v++) begin
      shift_word(vecs[v].sel, {64'h0, vecs[v].data}, 64, vecs[v].last, 1'b0);
      tick();
      chk($sformatf("tbl%0d_blk", v), bif.blk_o, vecs[v].data);
      chk($sformatf("tbl%0d_type", v), bif.blk_type_o, vecs[v].exp_type);
      chk($sformatf("tbl%0d_last", v), bif.blk_last_o, vecs[v].exp_last);
      chk($sformatf("tbl%0d_valid", v), bif.blk_valid_o, 1);
      bif.blk_ready_i = 1'b1;
      tick();
      bif.blk_ready_i = 1'b0;
      chk($sformatf("tbl%0d_drained", v), bif.blk_valid_o, 0);
    end
    chk("tbl_err", err_o, 0);
    chk("tbl_key_kept", key_o, KEY);

    shift_word(SEL_AD, 128'h1, 64, 1'b0, 1'b0);
    tick();
    go = 1'b1;
    tick();
    tick();
    chk("go_full_init", init_o, 0);
    chk("go_full_err", err_o, 1);
    go = 1'b0;

    do_reset();
    go = 1'b1;
    tick();
    tick();
    go = 1'b0;
    chk("go_nokn_init", init_o, 0);
    chk("go_nokn_err", err_o, 1);

    do_reset();
    shift_word(SEL_PT, {64'h0, 64'hAAAAAAAAAAAAAAAA}, 64, 1'b0, 1'b0);
    shift_word(SEL_PT, {64'h0, 64'h5555555555555555}, 64, 1'b0, 1'b0);
    tick();
    chk("drop_blk", bif.blk_o, 64'hAAAAAAAAAAAAAAAA);
    chk("drop_valid", bif.blk_valid_o, 1);
    chk("drop_err", err_o, 1);

    do_reset();
    shift_word(SEL_PT, {64'h0, 64'hAAAAAAAAAAAAAAAA}, 64, 1'b0, 1'b0);
    shift_word(SEL_PT, {64'h0, 64'h5555555555555555}, 64, 1'b1, 1'b1);
    tick();
    chk("swap_blk", bif.blk_o, 64'h5555555555555555);
    chk("swap_valid", bif.blk_valid_o, 1);
    chk("swap_last", bif.blk_last_o, 1);
    chk("swap_err", err_o, 0);

    do_reset();
    shift_word(SEL_KEY, {128{1'b1}}, 40, 1'b0, 1'b0);
    shift_word(SEL_AD, {64'h0, {64{1'b1}}}, 64, 1'b0, 1'b0);
    tick();
    chk("sw_key", key_o, 0);
    chk("sw_blk", bif.blk_o, {64{1'b1}});
    chk("sw_valid", bif.blk_valid_o, 1);
    chk("sw_type", bif.blk_type_o, 0);
    chk("sw_err", err_o, 0);

    do_reset();
    shift_word(SEL_NONCE, NONCE, 100, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_nonce", nonce_o, 0);
    chk("mid_valid", bif.blk_valid_o, 0);
    chk("mid_knok", kn_ok_o, 0);
    chk("mid_err", err_o, 0);
    rst = 1'b0;
    shift_word(SEL_NONCE, NONCE, 128, 1'b0, 1'b0);
    chk("reload_nonce", nonce_o, NONCE);
    chk("reload_key", key_o, 0);
    chk("reload_err", err_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
